stim_playback_anasymod: RTL and testbench

// - Time-stamped stimulus player: the write-side counterpart of the trace port. Trace port samples probes out of tb;

---
 rtl/stim_playback_anasymod.sv | 156 +++++++++++++++
 tb/tb_stim_playback_anasymod.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_playback_anasymod.sv
// Time-stamped stimulus player: replays a host-loaded {timestamp,value} table onto stim_out,
// steering the time manager so emu_time lands exactly on each timestamp. Looping: STIM_PLAYBACK_LOOP_EN.
module stim_playback_anasymod #(
    parameter int                          DEPTH      = 256,
    parameter int                          AW         = $clog2(DEPTH),
    parameter int                          VAL_WIDTH  = 25,
    parameter int                          TIME_WIDTH = 64,
    parameter int                          DT_WIDTH   = 32,
    parameter logic [DT_WIDTH-1:0]         DT_MAX     = {DT_WIDTH{1'b1}},
    parameter logic signed [VAL_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                        emu_clk,
    input  logic                        emu_rst,
    input  logic [TIME_WIDTH-1:0]       emu_time,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [TIME_WIDTH-1:0]       wr_time,
    input  logic signed [VAL_WIDTH-1:0] wr_value,
    input  logic [AW:0]                 num_entries,
    input  logic                        arm,
    input  logic                        abort,
`ifdef STIM_PLAYBACK_LOOP_EN
    input  logic [TIME_WIDTH-1:0]       loop_period,
`endif
    output logic signed [VAL_WIDTH-1:0] stim_out,
    output logic [DT_WIDTH-1:0]         emu_dt_req,
    output logic                        busy,
    output logic                        done,
    output logic                        late,
    output logic                        wr_err
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_DONE} state_t;

    state_t                           state, state_n;
    logic [TIME_WIDTH+VAL_WIDTH-1:0]  mem [DEPTH];
    logic [TIME_WIDTH+VAL_WIDTH-1:0]  rd_q;
    logic [AW:0]                      ptr, ptr_inc, cnt;
    logic [TIME_WIDTH-1:0]            base, head_ts, diff, loop_step;
    logic signed [VAL_WIDTH-1:0]      head_val;
    logic                             table_open, wr_ok, start, hit, rewind, loop_go;

`ifdef STIM_PLAYBACK_LOOP_EN
    assign loop_step = loop_period;
`else
    assign loop_step = '0;
`endif
    assign loop_go    = (loop_step != '0);

    assign table_open = (state == S_IDLE) || (state == S_DONE);
    assign wr_ok      = wr_en && table_open;
    assign ptr_inc    = ptr + 1'b1;
    // rd_q only changes on a FETCH edge, so the head entry is stable for the whole RUN phase.
    assign head_ts    = rd_q[TIME_WIDTH+VAL_WIDTH-1:VAL_WIDTH] + base;
    assign head_val   = rd_q[VAL_WIDTH-1:0];
    assign diff       = head_ts - emu_time;

    always_ff @(posedge emu_clk) begin
        if (wr_ok)
            mem[wr_addr] <= {wr_time, wr_value};
        if (state == S_FETCH)
            rd_q <= mem[ptr[AW-1:0]];
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state;
        emu_dt_req = DT_MAX;
        busy       = 1'b0;
        done       = 1'b0;
        start      = 1'b0;
        hit        = 1'b0;
        rewind     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (arm) begin
                    if (num_entries == '0) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_FETCH;
                        start   = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                busy       = 1'b1;
                emu_dt_req = '0;
                state_n    = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (emu_time < head_ts) begin
                    // Saturate on the full-width distance before narrowing.
                    emu_dt_req = (diff > TIME_WIDTH'(DT_MAX)) ? DT_MAX : diff[DT_WIDTH-1:0];
                end else begin
                    emu_dt_req = '0;
                    hit        = 1'b1;
                    if (ptr_inc < cnt) begin
                        state_n = S_FETCH;
                    end else if (loop_go) begin
                        rewind  = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (abort) begin
            state_n = S_IDLE;
            start   = 1'b0;
            hit     = 1'b0;
        end
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            ptr      <= '0;
            cnt      <= '0;
            base     <= '0;
            stim_out <= INIT_VALUE;
            late     <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            if (wr_en && !table_open)
                wr_err <= 1'b1;
            if (abort) begin
                stim_out <= INIT_VALUE;
            end else if (start) begin
                cnt  <= num_entries;
                ptr  <= '0;
                base <= '0;
                late <= 1'b0;
            end else if (hit) begin
                stim_out <= head_val;
                if (emu_time > head_ts)
                    late <= 1'b1;
                if (rewind) begin
                    ptr  <= '0;
                    base <= base + loop_step;
                end else begin
                    ptr <= ptr_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_stim_playback_anasymod.sv
// Bench for stim_playback_anasymod: directed sequences, a dt boundary table, and randomized
// tables checked against a timestamp-walk model. Loop cases need STIM_PLAYBACK_LOOP_EN.
module tb_stim_playback_anasymod;
    localparam int AW = 8;
    localparam logic [31:0] DTMAX = 32'hFFFF_FFFF;

    logic               emu_clk = 1'b0;
    logic               emu_rst = 1'b1;
    logic [63:0]        emu_time = '0;
    logic               wr_en = 1'b0;
    logic [AW-1:0]      wr_addr = '0;
    logic [63:0]        wr_time = '0;
    logic signed [24:0] wr_value = '0;
    logic [AW:0]        num_entries = '0;
    logic               arm = 1'b0, abort = 1'b0;
    logic [63:0]        loop_period = '0;
    logic signed [24:0] stim_out;
    logic [31:0]        emu_dt_req;
    logic               busy, done, late, wr_err;

    stim_playback_anasymod dut (
        .emu_clk(emu_clk), .emu_rst(emu_rst), .emu_time(emu_time),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_time(wr_time), .wr_value(wr_value),
        .num_entries(num_entries), .arm(arm), .abort(abort),
`ifdef STIM_PLAYBACK_LOOP_EN
        .loop_period(loop_period),
`endif
        .stim_out(stim_out), .emu_dt_req(emu_dt_req), .busy(busy), .done(done),
        .late(late), .wr_err(wr_err)
    );

    always #5 emu_clk = ~emu_clk;

    // Time manager stand-in: advance by the requested dt, capped by the bench.
    logic        tm_load = 1'b1, tm_run = 1'b0;
    logic [63:0] tm_val = '0, tm_cap = 64'd1;
    always @(posedge emu_clk) begin
        if (tm_load)
            emu_time <= tm_val;
        else if (tm_run)
            emu_time <= emu_time + ((64'(emu_dt_req) < tm_cap) ? 64'(emu_dt_req) : tm_cap);
    end

    // Record every visible change of stim_out with the emulation time it appeared at.
    logic [63:0]        log_t[$];
    logic signed [24:0] log_v[$];
    logic signed [24:0] prev_stim = '0;
    always @(posedge emu_clk) begin
        #1;
        if (stim_out !== prev_stim) begin
            log_t.push_back(emu_time);
            log_v.push_back(stim_out);
        end
        prev_stim = stim_out;
    end

    int n_chk = 0, n_err = 0;
    logic [63:0]        tbl_ts [16];
    logic signed [24:0] tbl_v  [16];

    typedef struct {
        logic [63:0] ts;
        logic [63:0] now;
        logic [31:0] dt;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge emu_clk);
    endtask

    task automatic do_abort();
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic set_time(input logic [63:0] t);
        tm_run = 1'b0; tm_load = 1'b1; tm_val = t; tick(); tm_load = 1'b0;
    endtask

    task automatic wr(input int a, input logic [63:0] ts, input logic signed [24:0] v);
        wr_en = 1'b1; wr_addr = AW'(a); wr_time = ts; wr_value = v; tick(); wr_en = 1'b0;
    endtask

    task automatic load_tbl(input int n);
        for (int i = 0; i < n; i++) wr(i, tbl_ts[i], tbl_v[i]);
    endtask

    task automatic wait_done(input int budget);
        int cyc = 0;
        while (!done && cyc < budget) begin tick(); cyc++; end
        chk("done_timeout", 64'(done), 64'd1);
    endtask

    // Arm at t0 and compare against the timestamp walk: each entry is taken at max(now, ts),
    // and it is late when its timestamp is already behind the current time.
    task automatic play(input int n, input logic [63:0] t0, input logic [63:0] cap, input int budget);
        logic [63:0]        t, et[$];
        logic signed [24:0] pv, ev[$];
        logic               lt;
        set_time(t0);
        log_t.delete(); log_v.delete();
        pv = stim_out;
        num_entries = (AW+1)'(n); arm = 1'b1; tick(); arm = 1'b0;
        tm_cap = cap; tm_run = 1'b1;
        wait_done(budget);
        tm_run = 1'b0;
        t = t0; lt = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (tbl_ts[i] < t) lt = 1'b1; else t = tbl_ts[i];
            if (tbl_v[i] != pv) begin et.push_back(t); ev.push_back(tbl_v[i]); end
            pv = tbl_v[i];
        end
        chk("play_time", emu_time, t);
        chk("play_late", 64'(late), 64'(lt));
        chk("play_stim", 64'(stim_out), 64'(tbl_v[n-1]));
        chk("play_dt_done", 64'(emu_dt_req), 64'(DTMAX));
        chk("play_busy", 64'(busy), 64'd0);
        chk("play_nchg", 64'(log_t.size()), 64'(et.size()));
        for (int i = 0; i < et.size() && i < log_t.size(); i++) begin
            chk("play_chg_t", log_t[i], et[i]);
            chk("play_chg_v", 64'(log_v[i]), 64'(ev[i]));
        end
    endtask

    initial begin
        logic [63:0] ts;
        logic [31:0] r;
        int          n, cyc;

        vecs[0] = '{64'd10, 64'd0, 32'd10};
        vecs[1] = '{64'h100_0000_0000, 64'd0, DTMAX};
        vecs[2] = '{64'hFFFF_FFFF, 64'd0, 32'hFFFF_FFFF};
        vecs[3] = '{64'h1_0000_0000, 64'd0, DTMAX};
        vecs[4] = '{64'h1_0000_0005, 64'd10, 32'hFFFF_FFFB};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFE0, 32'd16};
        vecs[6] = '{64'd100, 64'd100, 32'd0};
        vecs[7] = '{64'd20, 64'd50, 32'd0};

        tick(); tick();
        emu_rst = 1'b0; tm_load = 1'b0;
        chk("rst_dt", 64'(emu_dt_req), 64'(DTMAX));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_late", 64'(late), 64'd0);
        chk("rst_wr_err", 64'(wr_err), 64'd0);
        chk("rst_stim", 64'(stim_out), 64'd0);

        // Three entries with a shared timestamp, exact landings.
        tbl_ts[0] = 10; tbl_v[0] = 100;
        tbl_ts[1] = 25; tbl_v[1] = -50;
        tbl_ts[2] = 25; tbl_v[2] = 7;
        load_tbl(3);
        set_time(0);
        log_t.delete(); log_v.delete();
        num_entries = 3; arm = 1'b1; tick(); arm = 1'b0;
        chk("ex1_fetch_dt", 64'(emu_dt_req), 64'd0);
        chk("ex1_fetch_busy", 64'(busy), 64'd1);
        tm_cap = 1000; tm_run = 1'b1; tick();
        chk("ex1_run_dt", 64'(emu_dt_req), 64'd10);
        wait_done(100);
        tm_run = 1'b0;
        chk("ex1_nchg", 64'(log_t.size()), 64'd3);
        if (log_t.size() == 3) begin
            chk("ex1_t0", log_t[0], 64'd10); chk("ex1_v0", 64'(log_v[0]), 64'(25'sd100));
            chk("ex1_t1", log_t[1], 64'd25); chk("ex1_v1", 64'(log_v[1]), 64'(-25'sd50));
            chk("ex1_t2", log_t[2], 64'd25); chk("ex1_v2", 64'(log_v[2]), 64'(25'sd7));
        end
        chk("ex1_dt", 64'(emu_dt_req), 64'(DTMAX));
        chk("ex1_late", 64'(late), 64'd0);
        chk("ex1_stim", 64'(stim_out), 64'(25'sd7));

        // Entry already in the past: applied immediately, flagged late.
        do_abort();
        wr(0, 64'd20, 25'sd5);
        set_time(50);
        num_entries = 1; arm = 1'b1; tick(); arm = 1'b0;
        tick();
        chk("late_run_stim", 64'(stim_out), 64'd0);
        chk("late_run_done", 64'(done), 64'd0);
        tick();
        chk("late_stim", 64'(stim_out), 64'(25'sd5));
        chk("late_done", 64'(done), 64'd1);
        chk("late_flag", 64'(late), 64'd1);

        // arm with zero entries goes straight to DONE.
        do_abort();
        num_entries = 0; arm = 1'b1; tick(); arm = 1'b0;
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);

        // Write during RUN is dropped and flagged; replay shows the original table.
        do_abort();
        tbl_ts[0] = 10;   tbl_v[0] = 100;
        tbl_ts[1] = 1000; tbl_v[1] = 200;
        tbl_ts[2] = 1010; tbl_v[2] = 300;
        load_tbl(3);
        set_time(0);
        num_entries = 3; arm = 1'b1; tick(); arm = 1'b0;
        tm_cap = 4; tm_run = 1'b1; tick(); tick();
        chk("wr_busy", 64'(busy), 64'd1);
        wr(1, 64'd1000, 25'sd99);
        chk("wr_err_set", 64'(wr_err), 64'd1);
        wait_done(1000);
        tm_run = 1'b0;
        play(3, 0, 8, 1000);
        chk("wr_err_sticky", 64'(wr_err), 64'd1);

        // abort while waiting on a far timestamp, then arm+abort together.
        do_abort();
        tbl_ts[1] = 1000; tbl_v[1] = 200;
        load_tbl(2);
        set_time(0);
        num_entries = 2; arm = 1'b1; tick(); arm = 1'b0;
        tm_cap = 1; tm_run = 1'b1;
        cyc = 0;
        while (stim_out != 25'sd100 && cyc < 200) begin tick(); cyc++; end
        chk("ab_stim100", 64'(stim_out), 64'(25'sd100));
        tick(); tick();
        chk("ab_busy_pre", 64'(busy), 64'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        tm_run = 1'b0;
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_stim", 64'(stim_out), 64'd0);
        chk("ab_dt", 64'(emu_dt_req), 64'(DTMAX));
        chk("ab_wr_err_kept", 64'(wr_err), 64'd1);
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        chk("armab_busy", 64'(busy), 64'd0);
        chk("armab_done", 64'(done), 64'd0);
        chk("armab_dt", 64'(emu_dt_req), 64'(DTMAX));

        // dt request boundaries: single entry, time frozen, first RUN cycle.
        for (int i = 0; i < 8; i++) begin
            do_abort();
            wr(0, vecs[i].ts, 25'sd3);
            set_time(vecs[i].now);
            num_entries = 1; arm = 1'b1; tick(); arm = 1'b0;
            chk("vec_fetch_dt", 64'(emu_dt_req), 64'd0);
            tick();
            chk("vec_run_dt", 64'(emu_dt_req), 64'(vecs[i].dt));
        end

        // Saturated steps until an exact landing at 2**40.
        do_abort();
        tbl_ts[0] = 64'h100_0000_0000; tbl_v[0] = -25'sd1234;
        load_tbl(1);
        play(1, 0, 64'h2_0000_0000, 400);

        // Reset mid-operation clears the sticky flags too.
        do_abort();
        tbl_ts[0] = 5; tbl_v[0] = 11;
        load_tbl(1);
        set_time(9);
        num_entries = 1; arm = 1'b1; tick(); arm = 1'b0;
        tick(); tick();
        chk("mid_late", 64'(late), 64'd1);
        emu_rst = 1'b1; tick(); emu_rst = 1'b0;
        chk("mid_rst_late", 64'(late), 64'd0);
        chk("mid_rst_wr_err", 64'(wr_err), 64'd0);
        chk("mid_rst_stim", 64'(stim_out), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);

        // Randomized tables, including equal and past timestamps.
        for (int it = 0; it < 40; it++) begin
            do_abort();
            n = 1 + int'($urandom_range(0, 7));
            ts = 64'($urandom_range(0, 60));
            for (int i = 0; i < n; i++) begin
                ts = ts + 64'($urandom_range(0, 15));
                r = $urandom();
                tbl_ts[i] = ts;
                tbl_v[i] = ($urandom_range(0, 3) == 0) ? 25'sd0 : r[24:0];
            end
            load_tbl(n);
            play(n, 64'($urandom_range(0, 50)),
                 ($urandom_range(0, 3) == 0) ? 64'd1000 : 64'($urandom_range(1, 8)), 2000);
        end

`ifdef STIM_PLAYBACK_LOOP_EN
        begin
            int done_hi;
            emu_rst = 1'b1; tick(); emu_rst = 1'b0;
            loop_period = 100;
            wr(0, 64'd10, 25'sd1);
            wr(1, 64'd30, 25'sd2);
            set_time(0);
            log_t.delete(); log_v.delete();
            num_entries = 2; arm = 1'b1; tick(); arm = 1'b0;
            tm_cap = 7; tm_run = 1'b1;
            cyc = 0; done_hi = 0;
            while (emu_time < 215 && cyc < 500) begin
                tick(); cyc++;
                if (done) done_hi++;
            end
            tm_run = 1'b0;
            chk("loop_no_done", 64'(done_hi), 64'd0);
            chk("loop_nchg_ge5", 64'(log_t.size() >= 5), 64'd1);
            if (log_t.size() >= 5) begin
                chk("loop_t0", log_t[0], 64'd10);  chk("loop_v0", 64'(log_v[0]), 64'd1);
                chk("loop_t1", log_t[1], 64'd30);  chk("loop_v1", 64'(log_v[1]), 64'd2);
                chk("loop_t2", log_t[2], 64'd110); chk("loop_v2", 64'(log_v[2]), 64'd1);
                chk("loop_t3", log_t[3], 64'd130); chk("loop_v3", 64'(log_v[3]), 64'd2);
                chk("loop_t4", log_t[4], 64'd210); chk("loop_v4", 64'(log_v[4]), 64'd1);
            end
            do_abort();
            set_time(0);
            num_entries = 2; arm = 1'b1; tick(); arm = 1'b0;
            tm_cap = 5; tm_run = 1'b1;
            cyc = 0;
            while (emu_time < 115 && cyc < 500) begin tick(); cyc++; end
            chk("loop_at115", emu_time, 64'd115);
            chk("loop_busy115", 64'(busy), 64'd1);
            emu_rst = 1'b1; tick(); emu_rst = 1'b0;
            tm_run = 1'b0;
            chk("loop_rst_busy", 64'(busy), 64'd0);
            chk("loop_rst_stim", 64'(stim_out), 64'd0);
            chk("loop_rst_dt", 64'(emu_dt_req), 64'(DTMAX));
            loop_period = 0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
